// File: rtl/alu_pkg.sv
// Shared ALU encoding, RV32I opcode/funct constants and the ID/EX bundle.
// Used by the ID-side decoder and the EX-stage ALU alike.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [3:0] BUBBLE_CTRL = ALU_ADD;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic                  valid;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  src_imm;
    logic                  branch;
    logic                  br_neg;
    logic                  illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:       1'b0,
    alu_control: BUBBLE_CTRL,
    src_imm:     1'b0,
    branch:      1'b0,
    br_neg:      1'b0,
    illegal:     1'b0
  };

  // alt picks SUB/SRA over ADD/SRL; ignored for other funct3
  function automatic logic [3:0] f3_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    op = ALU_ADD;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct -> ALU control decode.
// ALU_CTRL_ILLEGAL_CHECK_EN enables funct7 legality checks and illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  src_imm,
  output logic                  branch,
  output logic                  br_neg,
  output logic                  illegal
);

  logic       bad;
  logic [3:0] op;
  logic       imm;
  logic       br;
  logic       neg;

  always_comb begin
    op  = ALU_ADD;
    imm = 1'b0;
    br  = 1'b0;
    neg = 1'b0;
    bad = 1'b0;
    unique case (1'b1)
      opcode == OPC_OP: begin
        op = f3_alu(funct3, funct7[5]);
`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
        if (funct3 == F3_ADD || funct3 == F3_SR)
          bad = funct7 != F7_ZERO && funct7 != F7_ALT;
        else
          bad = funct7 != F7_ZERO;
`endif
      end
      opcode == OPC_OP_IMM: begin
        imm = 1'b1;
        op  = f3_alu(funct3,
                     funct7[5] && funct3 == F3_SR);
`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
        if (funct3 == F3_SLL)
          bad = funct7 != F7_ZERO;
        else if (funct3 == F3_SR)
          bad = funct7 != F7_ZERO && funct7 != F7_ALT;
`endif
      end
      opcode == OPC_LOAD  || opcode == OPC_STORE ||
      opcode == OPC_LUI   || opcode == OPC_AUIPC ||
      opcode == OPC_JALR  || opcode == OPC_JAL: begin
        imm = 1'b1;
      end
      opcode == OPC_BRANCH: begin
        br = 1'b1;
        unique case (funct3)
          F3_BEQ:  op = ALU_SUB;
          F3_BNE:  begin op = ALU_SUB; neg = 1'b1; end
          F3_BLT:  op = ALU_SLT;
          F3_BGE:  begin op = ALU_SLT; neg = 1'b1; end
          F3_BLTU: op = ALU_SLTU;
          F3_BGEU: begin op = ALU_SLTU; neg = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  // illegal encodings collapse to a plain non-branch ADD
  assign alu_control = bad ? ALU_ADD : op;
  assign src_imm     = imm & ~bad;
  assign branch      = br  & ~bad;
  assign br_neg      = neg & ~bad;

`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
  assign illegal = bad;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID-side ALU control decode registered into the ID/EX boundary.
// ex_illegal is live only with ALU_CTRL_ILLEGAL_CHECK_EN defined.
module alu_ctrl_stage
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic                  ex_alu_src_imm,
  output logic                  ex_branch,
  output logic                  ex_br_neg,
  output logic                  ex_illegal
);

  id_ex_t dec;
  id_ex_t q;

  assign dec.valid = 1'b1;

  alu_op_decode u_dec (
    .opcode      (id_opcode),
    .funct3      (id_funct3),
    .funct7      (id_funct7),
    .alu_control (dec.alu_control),
    .src_imm     (dec.src_imm),
    .branch      (dec.branch),
    .br_neg      (dec.br_neg),
    .illegal     (dec.illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= ID_EX_BUBBLE;
    else if (flush)
      q <= ID_EX_BUBBLE;
    else if (!stall)
      q <= id_valid ? dec : ID_EX_BUBBLE;
  end

  assign ex_valid       = q.valid;
  assign ex_alu_control = q.alu_control;
  assign ex_alu_src_imm = q.src_imm;
  assign ex_branch      = q.branch;
  assign ex_br_neg      = q.br_neg;
  assign ex_illegal     = q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage; hand-computed expectations.
// Illegal-flag expectations follow ALU_CTRL_ILLEGAL_CHECK_EN.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [2:0] id_funct3;
  logic [6:0] id_funct7;
  logic       stall;
  logic       flush;
  logic       ex_valid;
  logic [3:0] ex_alu_control;
  logic       ex_alu_src_imm;
  logic       ex_branch;
  logic       ex_br_neg;
  logic       ex_illegal;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3),
    .id_funct7      (id_funct7),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_alu_src_imm (ex_alu_src_imm),
    .ex_branch      (ex_branch),
    .ex_br_neg      (ex_br_neg),
    .ex_illegal     (ex_illegal)
  );

  // {valid, ctrl[3:0], src_imm, branch, br_neg, illegal}
  function automatic logic [8:0] pk(
    input logic       v,
    input logic [3:0] c,
    input logic       i,
    input logic       b,
    input logic       n,
    input logic       l
  );
    return {v, c, i, b, n, l};
  endfunction

  function automatic logic [8:0] obs();
    return {ex_valid, ex_alu_control, ex_alu_src_imm,
            ex_branch, ex_br_neg, ex_illegal};
  endfunction

  task automatic check(
    input string      tag,
    input logic [8:0] got,
    input logic [8:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(
    input logic       v,
    input logic [6:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    id_valid  = v;
    id_opcode = op;
    id_funct3 = f3;
    id_funct7 = f7;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] Z7 = 7'b0000000;
  localparam logic [6:0] A7 = 7'b0100000;

  logic ill_chk;

  initial begin
`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
    ill_chk = 1'b1;
`else
    ill_chk = 1'b0;
`endif
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    step(1'b1, R, 3'b000, A7);
    check("reset", obs(), pk(0, 4'h0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, R, 3'b000, A7);
    check("sub", obs(), pk(1, 4'h1, 0, 0, 0, 0));

    #2 rst = 1'b1;
    #1 check("async_rst", obs(), pk(0, 4'h0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, R, 3'b000, Z7);
    check("add_after_rst", obs(), pk(1, 4'h0, 0, 0, 0, 0));
    step(1'b1, R, 3'b101, A7);
    check("sra", obs(), pk(1, 4'h9, 0, 0, 0, 0));
    step(1'b1, R, 3'b011, Z7);
    check("sltu", obs(), pk(1, 4'h6, 0, 0, 0, 0));
    step(1'b1, R, 3'b000, 7'b0000001);
    check("r_bad_f7", obs(), pk(1, 4'h0, 0, 0, 0, ill_chk));

    step(1'b1, I, 3'b000, A7);
    check("addi_f7", obs(), pk(1, 4'h0, 1, 0, 0, 0));
    step(1'b1, I, 3'b101, A7);
    check("srai", obs(), pk(1, 4'h9, 1, 0, 0, 0));
    step(1'b1, I, 3'b001, A7);
    if (ill_chk)
      check("slli_bad", obs(), pk(1, 4'h0, 0, 0, 0, 1));
    else
      check("slli_bad", obs(), pk(1, 4'h7, 1, 0, 0, 0));
    step(1'b1, LD, 3'b010, A7);
    check("load", obs(), pk(1, 4'h0, 1, 0, 0, 0));

    step(1'b1, B, 3'b001, Z7);
    check("bne", obs(), pk(1, 4'h1, 0, 1, 1, 0));
    step(1'b1, B, 3'b111, Z7);
    check("bgeu", obs(), pk(1, 4'h6, 0, 1, 1, 0));
    step(1'b1, B, 3'b010, Z7);
    check("br_f3_010", obs(), pk(1, 4'h0, 0, 0, 0, ill_chk));
    step(1'b1, 7'b1111111, 3'b000, Z7);
    check("unk_opc", obs(), pk(1, 4'h0, 0, 0, 0, ill_chk));

    step(1'b1, B, 3'b100, Z7);
    check("blt", obs(), pk(1, 4'h5, 0, 1, 0, 0));
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, R, 3'b100, Z7);
      check("stall_hold", obs(), pk(1, 4'h5, 0, 1, 0, 0));
    end
    flush = 1'b1;
    step(1'b1, R, 3'b100, Z7);
    check("flush_stall", obs(), pk(0, 4'h0, 0, 0, 0, 0));
    flush = 1'b0;
    stall = 1'b0;
    step(1'b1, R, 3'b100, Z7);
    check("xor", obs(), pk(1, 4'h4, 0, 0, 0, 0));

    step(1'b1, B, 3'b000, Z7);
    check("beq", obs(), pk(1, 4'h1, 0, 1, 0, 0));
    step(1'b0, B, 3'b001, Z7);
    check("bubble", obs(), pk(0, 4'h0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
